// File: rtl/fifo_wide_to_narrow.sv
// fifo_wide_to_narrow: stores IN_WIDTH-bit words and hands them out as
// R = IN_WIDTH/OUT_WIDTH consecutive OUT_WIDTH-bit sub-words, first-word-fall-through.
// Optional macro FIFO_W2N_SIZE_EN adds the SIZE output (sub-words available).
//
// Handshake: a word is accepted on a rising edge when WRITE=1 and FULL=0; WRITE while
// FULL drops the word and sets the sticky OVERFLOW. A sub-word is consumed on a rising
// edge when READ=1 and EMPTY=0; DATA_OUT is valid whenever EMPTY=0 and READ while
// EMPTY has no effect. FULL counts only the word memory, not the output HOLD stage.
module fifo_wide_to_narrow #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter int DEPTH     = 4096,
  parameter int MSB_FIRST = 0
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 WRITE,
  input  logic [IN_WIDTH-1:0]  DATA_IN,
  output logic                 FULL,
  output logic                 OVERFLOW,
  input  logic                 READ,
  output logic                 EMPTY,
`ifdef FIFO_W2N_SIZE_EN
  output logic [$clog2((DEPTH+1)*(IN_WIDTH/OUT_WIDTH)+1)-1:0] SIZE,
`endif
  output logic [OUT_WIDTH-1:0] DATA_OUT
);

  localparam int R  = IN_WIDTH / OUT_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(R);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] SEL_LAST  = SW'(R - 1);

  logic [IN_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;
  logic [IN_WIDTH-1:0] hold_q, hold_d;
  logic                hold_valid_q, hold_valid_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic                overflow_q, overflow_d;

  logic [AW:0]   count;
  logic          full, mem_empty, wr_en, pop, pop_last, load;
  logic [SW-1:0] sub_idx;

  assign count     = wr_ptr_q - rd_ptr_q;
  assign full      = (count == DEPTH_CNT);
  assign mem_empty = (count == '0);
  assign wr_en     = WRITE & ~full;
  assign pop       = READ & hold_valid_q;
  assign pop_last  = pop & (sel_q == SEL_LAST);
  // HOLD refills when idle or when its last sub-word leaves this cycle (no bubble).
  assign load      = ~mem_empty & (~hold_valid_q | pop_last);

  // Word storage: plain write port, contents deliberately not reset.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= DATA_IN;
  end

  // Next-state for pointers, output stage and overflow flag.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    sel_d        = sel_q;
    overflow_d   = overflow_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (WRITE && full) overflow_d = 1'b1;
    // SEL wraps explicitly at R-1 so non-power-of-two ratios work.
    if (pop) sel_d = pop_last ? '0 : sel_q + SW'(1);
    if (load) begin
      hold_d       = mem_q[rd_ptr_q[AW-1:0]];
      hold_valid_d = 1'b1;
      rd_ptr_d     = rd_ptr_q + (AW+1)'(1);
    end else if (pop_last) begin
      hold_valid_d = 1'b0;
    end
  end

  // State registers; async reset discards everything including a partial HOLD word.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      sel_q        <= '0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      sel_q        <= sel_d;
      overflow_q   <= overflow_d;
    end
  end

  assign sub_idx = (MSB_FIRST != 0) ? (SEL_LAST - sel_q) : sel_q;

  // Output sub-word mux, driven from registers only.
  always_comb begin
    DATA_OUT = '0;
    for (int i = 0; i < R; i++) begin
      if (sub_idx == SW'(i)) DATA_OUT = hold_q[i*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  assign FULL     = full;
  assign OVERFLOW = overflow_q;
  assign EMPTY    = ~hold_valid_q;

`ifdef FIFO_W2N_SIZE_EN
  localparam int ZW = $clog2((DEPTH+1)*R+1);
  assign SIZE = ZW'(count) * ZW'(R) + (hold_valid_q ? (ZW'(R) - ZW'(sel_q)) : '0);
`endif

endmodule

// File: tb/tb_fifo_wide_to_narrow.sv
// Directed bench for fifo_wide_to_narrow: three instances (LSB-first 32->8,
// MSB-first 32->8, 24->8), all DEPTH=4, sharing clock and reset.
module tb_fifo_wide_to_narrow;

  logic clk;
  logic rst_n;

  logic        w0, r0, full0, ovf0, empty0;
  logic [31:0] d0;
  logic [7:0]  do0;
  logic        w1, r1, full1, ovf1, empty1;
  logic [31:0] d1;
  logic [7:0]  do1;
  logic        w2, r2, full2, ovf2, empty2;
  logic [23:0] d2;
  logic [7:0]  do2;
`ifdef FIFO_W2N_SIZE_EN
  logic [4:0] size0, size1;
  logic [3:0] size2;
`endif

  int n_total = 0;
  int n_bad   = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] words [7];

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fifo_wide_to_narrow #(.IN_WIDTH(32), .OUT_WIDTH(8), .DEPTH(4), .MSB_FIRST(0)) u0 (
    .CLK(clk), .RST_N(rst_n), .WRITE(w0), .DATA_IN(d0), .FULL(full0), .OVERFLOW(ovf0),
    .READ(r0), .EMPTY(empty0),
`ifdef FIFO_W2N_SIZE_EN
    .SIZE(size0),
`endif
    .DATA_OUT(do0));

  fifo_wide_to_narrow #(.IN_WIDTH(32), .OUT_WIDTH(8), .DEPTH(4), .MSB_FIRST(1)) u1 (
    .CLK(clk), .RST_N(rst_n), .WRITE(w1), .DATA_IN(d1), .FULL(full1), .OVERFLOW(ovf1),
    .READ(r1), .EMPTY(empty1),
`ifdef FIFO_W2N_SIZE_EN
    .SIZE(size1),
`endif
    .DATA_OUT(do1));

  fifo_wide_to_narrow #(.IN_WIDTH(24), .OUT_WIDTH(8), .DEPTH(4), .MSB_FIRST(0)) u2 (
    .CLK(clk), .RST_N(rst_n), .WRITE(w2), .DATA_IN(d2), .FULL(full2), .OVERFLOW(ovf2),
    .READ(r2), .EMPTY(empty2),
`ifdef FIFO_W2N_SIZE_EN
    .SIZE(size2),
`endif
    .DATA_OUT(do2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue the bytes of a 32-bit word in LSB-first order.
  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[b*8 +: 8]);
  endtask

  // Continuous READ on u0 for n cycles, optionally with a WRITE of wdata at cycle wr_at.
  task automatic read_u0(input int n, input int wr_at, input logic [31:0] wdata);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      check($sformatf("rd_empty%0d", i), {31'd0, empty0}, 32'd0);
      check($sformatf("rd_data%0d", i), {24'd0, do0}, {24'd0, e});
      if (i == wr_at) begin
        check("full_before_rw", {31'd0, full0}, 32'd1);
        w0 = 1'b1;
        d0 = wdata;
      end else begin
        w0 = 1'b0;
      end
      r0 = 1'b1;
      step();
      if (i == wr_at) check("full_after_rw", {31'd0, full0}, 32'd0);
    end
    r0 = 1'b0;
    w0 = 1'b0;
    check("rd_done_empty", {31'd0, empty0}, 32'd1);
  endtask

  initial begin
    words[0] = 32'h0302_0100;
    words[1] = 32'h1312_1110;
    words[2] = 32'h2322_2120;
    words[3] = 32'h3332_3130;
    words[4] = 32'h4342_4140;
    words[5] = 32'hDEAD_BEEF;
    words[6] = 32'hCAFE_F00D;
    {w0, r0, w1, r1, w2, r2} = '0;
    d0 = '0; d1 = '0; d2 = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Reset state
    check("rst_empty", {31'd0, empty0}, 32'd1);
    check("rst_full", {31'd0, full0}, 32'd0);
    check("rst_ovf", {31'd0, ovf0}, 32'd0);
    check("rst_dout", {24'd0, do0}, 32'd0);
`ifdef FIFO_W2N_SIZE_EN
    check("rst_size", {27'd0, size0}, 32'd0);
`endif

    // Single word, LSB first, two-cycle latency, read while empty
    d0 = 32'hAABB_CCDD; w0 = 1'b1;
    step();
    w0 = 1'b0;
    check("lat_empty_n", {31'd0, empty0}, 32'd1);
    step();
    check("lat_empty_n1", {31'd0, empty0}, 32'd0);
    exp_q.push_back(8'hDD); exp_q.push_back(8'hCC);
    exp_q.push_back(8'hBB); exp_q.push_back(8'hAA);
    read_u0(4, -1, '0);
    r0 = 1'b1;
    step();
    r0 = 1'b0;
    check("rd_while_empty", {31'd0, empty0}, 32'd1);
    check("dout_stable", {24'd0, do0}, 32'h0000_00DD);

    // MSB first on u1
    d1 = 32'hAABB_CCDD; w1 = 1'b1;
    step();
    w1 = 1'b0;
    step();
    check("msb_d0", {24'd0, do1}, 32'h0000_00AA);
    r1 = 1'b1;
    step();
    check("msb_d1", {24'd0, do1}, 32'h0000_00BB);
    step();
    check("msb_d2", {24'd0, do1}, 32'h0000_00CC);
    step();
    check("msb_d3", {24'd0, do1}, 32'h0000_00DD);
    step();
    r1 = 1'b0;
    check("msb_empty", {31'd0, empty1}, 32'd1);

    // Fill u0 to FULL (HOLD takes the first word), then overflow
    for (int i = 0; i < 6; i++) begin
      d0 = words[i]; w0 = 1'b1;
      step();
      if (i == 3) check("full_after4", {31'd0, full0}, 32'd0);
      if (i == 4) begin
        check("full_after5", {31'd0, full0}, 32'd1);
        check("ovf_before", {31'd0, ovf0}, 32'd0);
      end
      if (i < 5) push_word(words[i]);
    end
    w0 = 1'b0;
    check("ovf_set", {31'd0, ovf0}, 32'd1);
`ifdef FIFO_W2N_SIZE_EN
    check("size_full", {27'd0, size0}, 32'd20);
`endif
    // Drain all 20 sub-words; the WRITE at the word boundary is dropped (FULL pre-edge)
    read_u0(20, 3, words[6]);
    check("ovf_sticky", {31'd0, ovf0}, 32'd1);

    // Three words, READ held 12 cycles with no bubble
    for (int i = 0; i < 3; i++) begin
      d0 = words[i+1]; w0 = 1'b1;
      step();
      push_word(words[i+1]);
    end
    w0 = 1'b0;
    read_u0(12, -1, '0);

    // R=3 on u2: two words, SEL wraps at 2
    d2 = 24'h12_3456; w2 = 1'b1;
    step();
    d2 = 24'hAB_CDEF;
    step();
    w2 = 1'b0;
    check("r3_d0", {24'd0, do2}, 32'h56);
    r2 = 1'b1;
    step();
    check("r3_d1", {24'd0, do2}, 32'h34);
    step();
    check("r3_d2", {24'd0, do2}, 32'h12);
    step();
    check("r3_d3", {24'd0, do2}, 32'hEF);
    step();
    check("r3_d4", {24'd0, do2}, 32'hCD);
    step();
    check("r3_d5", {24'd0, do2}, 32'hAB);
    step();
    r2 = 1'b0;
    check("r3_empty", {31'd0, empty2}, 32'd1);

    // Reset mid-word on u0: 5 words stored, 2 sub-words popped
    for (int i = 0; i < 5; i++) begin
      d0 = words[i]; w0 = 1'b1;
      step();
    end
    w0 = 1'b0;
    r0 = 1'b1;
    step();
    step();
    r0 = 1'b0;
    check("pre_rst_full", {31'd0, full0}, 32'd1);
    check("pre_rst_ovf", {31'd0, ovf0}, 32'd1);
    check("pre_rst_dout", {24'd0, do0}, 32'h02);
`ifdef FIFO_W2N_SIZE_EN
    check("pre_rst_size", {27'd0, size0}, 32'd18);
`endif
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_empty", {31'd0, empty0}, 32'd1);
    check("mid_rst_full", {31'd0, full0}, 32'd0);
    check("mid_rst_ovf", {31'd0, ovf0}, 32'd0);
    check("mid_rst_dout", {24'd0, do0}, 32'd0);
`ifdef FIFO_W2N_SIZE_EN
    check("mid_rst_size", {27'd0, size0}, 32'd0);
`endif
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_empty", {31'd0, empty0}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
